// File: rtl/bus_snoop_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bus_snoop_responder_pkg                                      |
// | Description : Shared LLC bus definitions: bus operation and snoop result   |
// |               encodings, the completion source encoding, and the rule that |
// |               maps an address to a snoop result.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bus_snoop_responder_pkg;

  // Three bits wide so that encodings 4..7 exist and can be flagged as illegal.
  typedef enum logic [2:0] {
    READ       = 3'd0,
    WRITE      = 3'd1,
    INVALIDATE = 3'd2,
    RWIM       = 3'd3
  } busOperation;

  typedef enum logic [1:0] {
    NOHIT = 2'd0,
    HIT   = 2'd1,
    HITM  = 2'd2
  } snoopResults;

  // SRC_NONE is the reset value of the completion source.
  typedef enum logic [1:0] {
    SRC_NONE    = 2'd0,
    SRC_MEM     = 2'd1,
    SRC_SNOOPER = 2'd2
  } respSource;

  // The other caches' snoop response is a pure function of the low address
  // bits, so the LLC bench can predict it without modelling any cache state.
  function automatic snoopResults snoop_from_addr(input logic [1:0] addr_lo);
    case (addr_lo)
      2'b00:   snoop_from_addr = HIT;
      2'b01:   snoop_from_addr = HITM;
      default: snoop_from_addr = NOHIT;
    endcase
  endfunction

  function automatic logic is_legal_op(input busOperation op);
    case (op)
      READ, WRITE, INVALIDATE, RWIM: is_legal_op = 1'b1;
      default:                       is_legal_op = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_snoop_responder_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sat_counter                                                  |
// | Description : Event counter that sticks at all-ones instead of wrapping.   |
// |   clk   in   clock                                                         |
// |   rst_n in   asynchronous active-low reset (count -> 0)                    |
// |   inc   in   count one event this cycle                                    |
// |   clear in   synchronous clear, has priority over inc                       |
// |   cnt   out  current count                                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/bus_snoop_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bus_snoop_responder                                          |
// | Description : Far end of the LLC shared bus (peer caches + DRAM). Takes    |
// |               one bus operation at a time, returns a snoop result, runs a  |
// |               memory or owner-flush phase and signals completion.          |
// |   req_valid/req_ready/req_op/req_addr  request handshake from the LLC      |
// |   snoop_valid/snoop_result             one-cycle snoop result pulse        |
// |   resp_valid/resp_addr/resp_src/resp_err  completion pulse + held info     |
// |   busy                                 transaction in flight               |
// |   txn_cnt/hitm_cnt/mem_cnt             saturating statistics               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bus_snoop_responder
  import bus_snoop_responder_pkg::*;
#(
  parameter int SNOOP_LAT  = 1,
  parameter int MEM_RD_LAT = 4,
  parameter int MEM_WR_LAT = 2,
  parameter int LINE_BYTES = 64,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  busOperation       req_op,
  input  logic [31:0]       req_addr,
  output logic              snoop_valid,
  output snoopResults       snoop_result,
  output logic              resp_valid,
  output logic [31:0]       resp_addr,
  output respSource         resp_src,
  output logic              resp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_cnt,
  output logic [CNT_W-1:0]  hitm_cnt,
  output logic [CNT_W-1:0]  mem_cnt
);

  localparam int c_lat_max_a = (SNOOP_LAT > MEM_RD_LAT) ? SNOOP_LAT : MEM_RD_LAT;
  localparam int c_lat_max   = (c_lat_max_a > MEM_WR_LAT) ? c_lat_max_a : MEM_WR_LAT;
  // The down-counter holds latency-1, so clog2(max) bits suffice.
  localparam int c_lat_w     = (c_lat_max > 1) ? $clog2(c_lat_max) : 1;
  localparam logic [31:0] c_line_mask = ~(32'(LINE_BYTES) - 32'd1);

  // MEM is the post-snoop latency phase. INVALIDATE and illegal ops pass
  // through it for exactly one cycle without counting as a memory phase.
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_snoop = 2'd1;
  localparam logic [1:0] c_st_mem   = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [c_lat_w-1:0] lat_cnt_q, lat_cnt_d;
  busOperation        op_q, op_d;
  logic [31:0]        addr_q, addr_d;
  respSource          pend_src_q, pend_src_d;
  logic               pend_err_q, pend_err_d;
  logic               snoop_valid_q, snoop_valid_d;
  snoopResults        snoop_result_q, snoop_result_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_addr_q, resp_addr_d;
  respSource          resp_src_q, resp_src_d;
  logic               resp_err_q, resp_err_d;

  logic               w_accept;
  logic               w_snoop_done;
  logic               w_mem_done;
  logic               w_legal;
  snoopResults        w_snoop_res;
  logic [c_lat_w-1:0] w_phase_lat;
  respSource          w_phase_src;
  logic               w_mem_phase;

  assign w_accept     = req_valid && (state_q == c_st_idle);
  assign w_snoop_done = (state_q == c_st_snoop) && (lat_cnt_q == '0);
  assign w_mem_done   = (state_q == c_st_mem) && (lat_cnt_q == '0);
  assign w_legal      = is_legal_op(op_q);
  // The unmasked captured address drives the snoop rule.
  assign w_snoop_res  = w_legal ? snoop_from_addr(addr_q[1:0]) : NOHIT;

  // Length (minus one) and source of the phase that follows the snoop.
  always_comb begin
    w_phase_lat = '0;
    w_phase_src = SRC_NONE;
    w_mem_phase = 1'b0;
    if (w_legal) begin
      case (op_q)
        READ, RWIM: begin
          w_mem_phase = 1'b1;
          if (w_snoop_res == HITM) begin
            // Modified owner flushes the line instead of DRAM supplying it.
            w_phase_lat = c_lat_w'(MEM_WR_LAT - 1);
            w_phase_src = SRC_SNOOPER;
          end else begin
            w_phase_lat = c_lat_w'(MEM_RD_LAT - 1);
            w_phase_src = SRC_MEM;
          end
        end
        WRITE: begin
          w_mem_phase = 1'b1;
          w_phase_lat = c_lat_w'(MEM_WR_LAT - 1);
          w_phase_src = SRC_MEM;
        end
        default: begin
          w_phase_lat = '0;
          w_phase_src = SRC_NONE;
          w_mem_phase = 1'b0;
        end
      endcase
    end
  end

  // State register (plus datapath flops).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= c_st_idle;
      lat_cnt_q      <= '0;
      op_q           <= READ;
      addr_q         <= '0;
      pend_src_q     <= SRC_NONE;
      pend_err_q     <= 1'b0;
      snoop_valid_q  <= 1'b0;
      snoop_result_q <= NOHIT;
      resp_valid_q   <= 1'b0;
      resp_addr_q    <= '0;
      resp_src_q     <= SRC_NONE;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      lat_cnt_q      <= lat_cnt_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      pend_src_q     <= pend_src_d;
      pend_err_q     <= pend_err_d;
      snoop_valid_q  <= snoop_valid_d;
      snoop_result_q <= snoop_result_d;
      resp_valid_q   <= resp_valid_d;
      resp_addr_q    <= resp_addr_d;
      resp_src_q     <= resp_src_d;
      resp_err_q     <= resp_err_d;
    end
  end

  // Next-state logic and latency down-counter.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      c_st_idle: begin
        if (w_accept) begin
          state_d   = c_st_snoop;
          lat_cnt_d = c_lat_w'(SNOOP_LAT - 1);
        end
      end
      c_st_snoop: begin
        if (lat_cnt_q == '0) begin
          state_d   = c_st_mem;
          lat_cnt_d = w_phase_lat;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      c_st_mem: begin
        if (lat_cnt_q == '0) begin
          state_d = c_st_done;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      c_st_done: begin
        // resp_valid is visible in this cycle; ready returns next cycle.
        state_d = c_st_idle;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    op_d           = op_q;
    addr_d         = addr_q;
    pend_src_d     = pend_src_q;
    pend_err_d     = pend_err_q;
    snoop_valid_d  = 1'b0;
    snoop_result_d = snoop_result_q;
    resp_valid_d   = 1'b0;
    resp_addr_d    = resp_addr_q;
    resp_src_d     = resp_src_q;
    resp_err_d     = resp_err_q;
    if (w_accept) begin
      op_d   = req_op;
      addr_d = req_addr;
    end
    if (w_snoop_done) begin
      snoop_valid_d  = 1'b1;
      snoop_result_d = w_snoop_res;
      pend_src_d     = w_phase_src;
      pend_err_d     = !w_legal;
    end
    if (w_mem_done) begin
      resp_valid_d = 1'b1;
      resp_addr_d  = addr_q & c_line_mask;
      resp_src_d   = pend_src_q;
      resp_err_d   = pend_err_q;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_txn_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_accept),
    .clear (1'b0),
    .cnt   (txn_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hitm_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_snoop_done && (w_snoop_res == HITM)),
    .clear (1'b0),
    .cnt   (hitm_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mem_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_snoop_done && w_mem_phase),
    .clear (1'b0),
    .cnt   (mem_cnt)
  );

  assign req_ready    = (state_q == c_st_idle);
  assign busy         = !req_ready;
  assign snoop_valid  = snoop_valid_q;
  assign snoop_result = snoop_result_q;
  assign resp_valid   = resp_valid_q;
  assign resp_addr    = resp_addr_q;
  assign resp_src     = resp_src_q;
  assign resp_err     = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_snoop_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bus_snoop_responder                                       |
// | Description : Directed, table-driven bench for bus_snoop_responder with    |
// |               hand-written reset and back-to-back sequences.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bus_snoop_responder;
  import bus_snoop_responder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  busOperation req_op;
  logic [31:0] req_addr;

  logic        req_ready, snoop_valid, resp_valid, resp_err, busy;
  snoopResults snoop_result;
  logic [31:0] resp_addr;
  respSource   resp_src;
  logic [31:0] txn_cnt, hitm_cnt, mem_cnt;

  // Narrow-counter copy used only to observe saturation.
  logic        s_req_ready, s_snoop_valid, s_resp_valid, s_resp_err, s_busy;
  snoopResults s_snoop_result;
  logic [31:0] s_resp_addr;
  respSource   s_resp_src;
  logic [1:0]  s_txn_cnt, s_hitm_cnt, s_mem_cnt;

  int total = 0;
  int bad   = 0;

  bus_snoop_responder #(
    .SNOOP_LAT(1), .MEM_RD_LAT(4), .MEM_WR_LAT(2), .LINE_BYTES(64), .CNT_W(32)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .snoop_valid(snoop_valid),
    .snoop_result(snoop_result), .resp_valid(resp_valid), .resp_addr(resp_addr),
    .resp_src(resp_src), .resp_err(resp_err), .busy(busy), .txn_cnt(txn_cnt),
    .hitm_cnt(hitm_cnt), .mem_cnt(mem_cnt)
  );

  bus_snoop_responder #(
    .SNOOP_LAT(1), .MEM_RD_LAT(4), .MEM_WR_LAT(2), .LINE_BYTES(64), .CNT_W(2)
  ) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_op(req_op), .req_addr(req_addr), .snoop_valid(s_snoop_valid),
    .snoop_result(s_snoop_result), .resp_valid(s_resp_valid), .resp_addr(s_resp_addr),
    .resp_src(s_resp_src), .resp_err(s_resp_err), .busy(s_busy), .txn_cnt(s_txn_cnt),
    .hitm_cnt(s_hitm_cnt), .mem_cnt(s_mem_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    busOperation op;
    logic [31:0] addr;
    snoopResults snp;
    int          resp_cyc;
    logic [31:0] raddr;
    respSource   src;
    logic        err;
    int          txn;
    int          hitm;
    int          mem;
  } vec_t;

  vec_t vecs[8];

  // Issue one request from an idle negedge and check the whole transaction.
  // Cycle c is the interval after the c-th posedge counted from the accept edge.
  task automatic run_vec(input vec_t v, input int idx);
    int snoop_cyc = -1;
    int resp_cyc  = -1;
    int npulse    = 0;
    int wait_n    = 0;
    snoopResults sres = NOHIT;
    logic [31:0] raddr = '0;
    respSource   rsrc = SRC_NONE;
    logic        rerr = 1'b0;
    string       tag;
    tag = $sformatf("v%0d", idx);
    while (!req_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    chk({tag, "_ready_at_start"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_addr  = v.addr;
    @(posedge clk);
    for (int c = 0; c < 20 && resp_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 0) begin
        // Scramble inputs while busy; the captured request must not change.
        req_valid = 1'b0;
        req_op    = RWIM;
        req_addr  = 32'hDEAD_BEEF;
        chk({tag, "_busy_c0"}, {31'd0, busy}, 32'd1);
      end
      if (snoop_valid) begin
        npulse++;
        snoop_cyc = c;
        sres = snoop_result;
      end
      if (resp_valid) begin
        resp_cyc = c;
        raddr = resp_addr;
        rsrc  = resp_src;
        rerr  = resp_err;
      end
    end
    chk({tag, "_snoop_cycle"}, 32'(snoop_cyc), 32'd1);
    chk({tag, "_snoop_pulses"}, 32'(npulse), 32'd1);
    chk({tag, "_snoop_result"}, 32'(sres), 32'(v.snp));
    chk({tag, "_resp_cycle"}, 32'(resp_cyc), 32'(v.resp_cyc));
    chk({tag, "_resp_addr"}, raddr, v.raddr);
    chk({tag, "_resp_src"}, 32'(rsrc), 32'(v.src));
    chk({tag, "_resp_err"}, {31'd0, rerr}, {31'd0, v.err});
    @(negedge clk);
    chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_resp_pulse_end"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_held_addr"}, resp_addr, v.raddr);
    chk({tag, "_txn_cnt"}, txn_cnt, 32'(v.txn));
    chk({tag, "_hitm_cnt"}, hitm_cnt, 32'(v.hitm));
    chk({tag, "_mem_cnt"}, mem_cnt, 32'(v.mem));
  endtask

  initial begin
    int r1;
    int r2;
    logic ready_low_ok;
    logic saw_resp;

    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_op    = READ;
    req_addr  = '0;

    //                op                     addr          snp    rc  raddr         src          err txn hitm mem
    vecs[0] = '{READ,                  32'h1000_0002, NOHIT, 5, 32'h1000_0000, SRC_MEM,     1'b0, 1, 0, 1};
    vecs[1] = '{RWIM,                  32'h2000_0041, HITM,  3, 32'h2000_0040, SRC_SNOOPER, 1'b0, 2, 1, 2};
    vecs[2] = '{INVALIDATE,            32'h0000_0000, HIT,   2, 32'h0000_0000, SRC_NONE,    1'b0, 3, 1, 2};
    vecs[3] = '{WRITE,                 32'h0000_0041, HITM,  3, 32'h0000_0040, SRC_MEM,     1'b0, 4, 2, 3};
    vecs[4] = '{READ,                  32'h3000_007C, HIT,   5, 32'h3000_0040, SRC_MEM,     1'b0, 5, 2, 4};
    vecs[5] = '{busOperation'(3'd5),   32'h1234_5679, NOHIT, 2, 32'h1234_5640, SRC_NONE,    1'b1, 6, 2, 4};
    vecs[6] = '{RWIM,                  32'hFFFF_FFFF, NOHIT, 5, 32'hFFFF_FFC0, SRC_MEM,     1'b0, 7, 2, 5};
    vecs[7] = '{INVALIDATE,            32'h0000_0001, HITM,  2, 32'h0000_0000, SRC_NONE,    1'b0, 8, 3, 5};

    // Reset asserted mid-clock acts immediately.
    #12 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_snoop_valid", {31'd0, snoop_valid}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_addr", resp_addr, 32'd0);
    chk("rst_resp_src", 32'(resp_src), 32'(SRC_NONE));
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_txn_cnt", txn_cnt, 32'd0);
    chk("rst_hitm_cnt", hitm_cnt, 32'd0);
    chk("rst_mem_cnt", mem_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end
    chk("sat_txn_cnt", 32'(s_txn_cnt), 32'd3);
    chk("sat_hitm_cnt", 32'(s_hitm_cnt), 32'd3);
    chk("sat_mem_cnt", 32'(s_mem_cnt), 32'd3);

    // Back-to-back: req_valid held, second request waits for the first to finish.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = WRITE;
    req_addr  = 32'h0000_0040;
    @(posedge clk);
    r1 = -1;
    r2 = -1;
    ready_low_ok = 1'b1;
    for (int c = 0; c < 30 && r2 < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_op   = READ;
        req_addr = 32'h0000_0080;
      end
      if (c >= 1 && c <= 3 && req_ready) ready_low_ok = 1'b0;
      if (resp_valid && r1 < 0) begin
        r1 = c;
        chk("b2b_resp1_addr", resp_addr, 32'h0000_0040);
        chk("b2b_resp1_src", 32'(resp_src), 32'(SRC_MEM));
      end else if (resp_valid) begin
        r2 = c;
        chk("b2b_resp2_addr", resp_addr, 32'h0000_0080);
        chk("b2b_resp2_src", 32'(resp_src), 32'(SRC_MEM));
      end
      if (c == 4) begin
        chk("b2b_ready_c4", {31'd0, req_ready}, 32'd1);
        chk("b2b_txn_c4", txn_cnt, 32'd1);
      end
      if (c == 5) begin
        chk("b2b_busy_c5", {31'd0, req_ready}, 32'd0);
        chk("b2b_txn_c5", txn_cnt, 32'd2);
        req_valid = 1'b0;
      end
    end
    chk("b2b_ready_low_c1_3", {31'd0, ready_low_ok}, 32'd1);
    chk("b2b_resp1_cycle", 32'(r1), 32'd3);
    chk("b2b_resp2_cycle", 32'(r2), 32'd10);
    @(negedge clk);

    // Reset during the READ memory phase discards the transaction.
    req_valid = 1'b1;
    req_op    = READ;
    req_addr  = 32'h0000_0100;
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_txn_cnt", txn_cnt, 32'd0);
    chk("midrst_mem_cnt", mem_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_resp = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid || snoop_valid) saw_resp = 1'b1;
    end
    chk("midrst_no_resp", {31'd0, saw_resp}, 32'd0);
    chk("midrst_ready_after", {31'd0, req_ready}, 32'd1);
    chk("midrst_cnt_after", txn_cnt | hitm_cnt | mem_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
